sample_dac_out: RTL

SAMPLE_DAC_OUT -- requirements
Module: sample_dac_out

---
 rtl/sample_dac_out_if.sv | 14 +
 rtl/sample_dac_out.sv | 45 ++++
 2 files changed

// File: rtl/sample_dac_out_if.sv
// sample_dac_out_if: sample stream in, 1-bit audio and status out for the DAC output stage.
interface sample_dac_out_if #(parameter int WAVE_BITS = 8);
   logic signed [WAVE_BITS-1:0] sample_in;
   logic                        sample_valid;
   logic                        mode;
   logic                        clear_flags;
   logic                        dac_out;
   logic                        frame_start;
   logic                        overrun;
   modport master (output sample_in, sample_valid, mode, clear_flags,
                   input  dac_out, frame_start, overrun);
   modport slave  (input  sample_in, sample_valid, mode, clear_flags,
                   output dac_out, frame_start, overrun);
endinterface

// File: rtl/sample_dac_out.sv
// sample_dac_out: turns signed synth samples into a 1-bit PWM or first-order sigma-delta stream.
// Samples land in hold; a new frame begins every 2^WAVE_BITS cycles, when active and the mode latch update.
module sample_dac_out #(parameter int WAVE_BITS = 8) (
   input  logic            clk,
   input  logic            reset,
   sample_dac_out_if.slave bus
);
   localparam logic [WAVE_BITS-1:0] MID = {1'b1, {(WAVE_BITS-1){1'b0}}};
   logic [WAVE_BITS-1:0] r_cnt, r_hold, r_active, r_acc, w_u;
   logic [WAVE_BITS:0]   w_sum;
   logic                 r_mode, r_pending, r_overrun, r_dac, w_load;
   assign w_u   = {~bus.sample_in[WAVE_BITS-1], bus.sample_in[WAVE_BITS-2:0]};
   assign w_load = &r_cnt;
   assign w_sum = {1'b0, r_acc} + {1'b0, r_hold};
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt     <= '0;
         r_hold    <= MID;
         r_active  <= MID;
         r_acc     <= '0;
         r_mode    <= 1'b0;
         r_pending <= 1'b0;
         r_overrun <= 1'b0;
         r_dac     <= 1'b0;
      end else begin
         r_cnt     <= r_cnt + WAVE_BITS'(1);
         r_dac     <= r_mode ? w_sum[WAVE_BITS] : (r_cnt < r_active);
         // a sample arriving on the frame-load cycle is consumed at once, so it never overruns
         r_overrun <= (bus.sample_valid & r_pending & ~w_load) | (r_overrun & ~bus.clear_flags);
         if (bus.sample_valid) r_hold <= w_u;
         if (r_mode) r_acc <= w_sum[WAVE_BITS-1:0];
         if (w_load) begin
            r_active  <= bus.sample_valid ? w_u : r_hold;
            r_mode    <= bus.mode;
            r_pending <= 1'b0;
            if (bus.mode != r_mode) r_acc <= '0;
         end else if (bus.sample_valid) begin
            r_pending <= 1'b1;
         end
      end
   end
   assign bus.dac_out     = r_dac;
   assign bus.frame_start = (r_cnt == '0);
   assign bus.overrun     = r_overrun;
endmodule
